// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter issuing a registered one-hot grant; request to grant_valid is one cycle.
// grant holds while grant_ready is low; a transfer with pending requests reloads on the same edge.
module rr_onehot_arbiter #(
  parameter int NUM_REQ  = 16,
  parameter int PTR_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_mask,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  input  logic               grant_ready,
  output logic               busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]          state, state_nxt;
  logic [PTR_BITS-1:0] last_ptr, last_ptr_nxt;
  logic [NUM_REQ-1:0]  grant_nxt;
  logic                grant_valid_nxt;

  logic [NUM_REQ-1:0]  ereq;
  logic [PTR_BITS-1:0] grant_idx;
  logic [PTR_BITS-1:0] search_base;
  logic [NUM_REQ-1:0]  hi_mask;
  logic [NUM_REQ-1:0]  hi_req;
  logic [NUM_REQ-1:0]  winner;

  assign ereq = req & req_mask;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = grant_idx | PTR_BITS'(i);
    end
  end

  // On a transfer the pointer moves to the granted bit in the same cycle, so search from it directly.
  assign search_base = (state == ST_GRANT) ? grant_idx : last_ptr;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (i > int'(search_base));
    end
  end

  // Lowest set bit above the pointer wins; if none, wrap to the lowest set bit overall.
  assign hi_req = ereq & hi_mask;
  assign winner = (hi_req != '0) ? (hi_req & (~hi_req + 1'b1))
                                 : (ereq & (~ereq + 1'b1));

  always_comb begin
    state_nxt       = state;
    last_ptr_nxt    = last_ptr;
    grant_nxt       = grant;
    grant_valid_nxt = grant_valid;
    case (state)
      ST_IDLE: begin
        if (ereq != '0) begin
          grant_nxt       = winner;
          grant_valid_nxt = 1'b1;
          state_nxt       = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (grant_ready) begin
          last_ptr_nxt = grant_idx;
          if (winner != '0) begin
            grant_nxt = winner;
          end else begin
            grant_nxt       = '0;
            grant_valid_nxt = 1'b0;
            state_nxt       = ST_IDLE;
          end
        end
      end
      default: begin
        grant_nxt       = '0;
        grant_valid_nxt = 1'b0;
        state_nxt       = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_ptr    <= PTR_BITS'(NUM_REQ - 1);
      grant       <= '0;
      grant_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_ptr    <= last_ptr_nxt;
      grant       <= grant_nxt;
      grant_valid <= grant_valid_nxt;
      busy        <= (state_nxt == ST_GRANT);
    end
  end

  a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_valid_matches_grant: assert property (@(posedge clk) disable iff (rst) (grant != '0) == grant_valid);
  a_busy_matches_valid: assert property (@(posedge clk) disable iff (rst) busy == grant_valid);

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter: expected accepted grants queue up at stimulus time
// and a negedge monitor pops them on every valid/ready transfer.
module tb_rr_onehot_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] req_mask;
  logic [15:0] grant;
  logic        grant_valid;
  logic        grant_ready;
  logic        busy;

  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] exp_q[$];

  rr_onehot_arbiter #(.NUM_REQ(16), .PTR_BITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_mask    (req_mask),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted grant must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      compared++;
      if (busy !== grant_valid || ((grant != 16'h0) !== grant_valid) || !$onehot0(grant)) begin
        mismatched++;
        $display("FAIL invariant: grant=%h valid=%b busy=%b", grant, grant_valid, busy);
      end
      if (grant_valid && grant_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL xfer_unexpected: got grant=%h, expected no transfer", grant);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (grant !== e) begin
            mismatched++;
            $display("FAIL xfer_grant: got %h, expected %h", grant, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic [15:0] g, input logic v);
    compared++;
    if (grant !== g || grant_valid !== v || busy !== v) begin
      mismatched++;
      $display("FAIL %s: got grant=%h valid=%b busy=%b, expected grant=%h valid=%b busy=%b",
               name, grant, grant_valid, busy, g, v, v);
    end
  endtask

  task automatic check_drained(input string name);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s: %0d expected transfers still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; req = 16'h0; req_mask = 16'hFFFF; grant_ready = 1'b0;
    tick(); tick();
    check_state("reset", 16'h0, 1'b0);
    rst = 1'b0;

    // Idle with no requests; ready high must be ignored.
    grant_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_state("idle_no_req", 16'h0, 1'b0);
    end

    // Back-to-back alternation between bits 0 and 15.
    exp_q.push_back(16'h0001); exp_q.push_back(16'h8000);
    exp_q.push_back(16'h0001); exp_q.push_back(16'h8000);
    req = 16'h8001;
    tick();
    check_state("b2b_first_latency", 16'h0001, 1'b1);
    tick(); tick(); tick();
    req = 16'h0;
    tick();
    check_state("b2b_return_idle", 16'h0, 1'b0);
    check_drained("b2b_drain");

    // Hold under backpressure while the request drops.
    grant_ready = 1'b0;
    req = 16'h0004;
    tick();
    check_state("hold_c1", 16'h0004, 1'b1);
    req = 16'h0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      check_state("hold_cn", 16'h0004, 1'b1);
    end
    exp_q.push_back(16'h0004);
    grant_ready = 1'b1;
    tick();
    check_state("hold_release_idle", 16'h0, 1'b0);
    check_drained("hold_drain");

    // Mask restricts the rotation to bits 4..7.
    exp_q.push_back(16'h0010); exp_q.push_back(16'h0020); exp_q.push_back(16'h0040);
    exp_q.push_back(16'h0080); exp_q.push_back(16'h0010);
    req = 16'hFFFF; req_mask = 16'h00F0;
    for (int i = 0; i < 5; i++) tick();
    req = 16'h0; req_mask = 16'hFFFF;
    tick();
    check_state("mask_return_idle", 16'h0, 1'b0);
    check_drained("mask_drain");

    // Grant bit 15, then wrap the search to bit 1.
    exp_q.push_back(16'h8000); exp_q.push_back(16'h0002); exp_q.push_back(16'h8000);
    req = 16'h8000;
    tick();
    req = 16'h8002;
    tick();
    check_state("wrap_to_bit1", 16'h0002, 1'b1);
    tick();
    check_state("wrap_back_15", 16'h8000, 1'b1);
    req = 16'h0;
    tick();
    check_state("wrap_return_idle", 16'h0, 1'b0);
    check_drained("wrap_drain");

    // Reset drops a pending grant; pointer restarts so bit 0 wins.
    grant_ready = 1'b0;
    req = 16'h0100;
    tick();
    check_state("pre_reset_grant", 16'h0100, 1'b1);
    rst = 1'b1; req = 16'h0101;
    tick();
    check_state("midop_reset", 16'h0, 1'b0);
    rst = 1'b0;
    tick();
    check_state("post_reset_grant", 16'h0001, 1'b1);
    exp_q.push_back(16'h0001);
    grant_ready = 1'b1; req = 16'h0;
    tick();
    check_state("post_reset_idle", 16'h0, 1'b0);
    check_drained("final_drain");

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #50000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
